tpg_timing_ctrl: RTL

- Configuration and sequencing controller for the test pattern generator (TPG).
- Holds staging and active copies of the ten video timing values and drives the active copy onto the TPG timing inputs.
- Commits a new timing set only at a frame boundary (vs rising edge), holding the TPG in reset for a fixed number of cycles around the switch.
- Sits between the host configuration bus and the TPG; also validates timing sets and counts frames.

---
 rtl/tpg_pkg.sv | 17 +
 rtl/tpg_timing_check.sv | 23 ++
 rtl/tpg_timing_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tpg_pkg.sv
// tpg_pkg: shared timing indices, controller state encoding and sizes for the TPG timing controller.
// No ports; imported by tpg_timing_check and tpg_timing_ctrl.
package tpg_pkg;
    localparam int NUM_TIMING = 10;
    localparam int NUM_H      = 5;
    localparam int IDX_HS_START   = 0;
    localparam int IDX_HS_END     = 1;
    localparam int IDX_HACT_START = 2;
    localparam int IDX_HACT_END   = 3;
    localparam int IDX_H_END      = 4;
    localparam int IDX_VS_START   = 5;
    localparam int IDX_VS_END     = 6;
    localparam int IDX_VACT_START = 7;
    localparam int IDX_VACT_END   = 8;
    localparam int IDX_V_END      = 9;
    typedef enum logic [1:0] {IDLE, PEND, APPLY, HOLD} state_e;
endpackage

// File: rtl/tpg_timing_check.sv
// tpg_timing_check: combinational validity check of one horizontal/vertical timing set.
// Ports: h_i  - five horizontal values indexed IDX_HS_START..IDX_H_END
//        v_i  - five vertical values indexed (IDX_VS_START..IDX_V_END) - NUM_H
//        valid_o - all sync/active ordering constraints hold
module tpg_timing_check
    import tpg_pkg::*;
#(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12
) (
    input  logic [NUM_H-1:0][H_BITS-1:0] h_i,
    input  logic [NUM_H-1:0][V_BITS-1:0] v_i,
    output logic                         valid_o
);
    localparam int VB = NUM_H;
    logic h_ok;
    logic v_ok;
    assign h_ok = (h_i[IDX_HS_START] < h_i[IDX_HS_END]) && (h_i[IDX_HS_END] < h_i[IDX_H_END]) &&
                  (h_i[IDX_HACT_START] < h_i[IDX_HACT_END]) && (h_i[IDX_HACT_END] <= h_i[IDX_H_END]);
    assign v_ok = (v_i[IDX_VS_START-VB] < v_i[IDX_VS_END-VB]) && (v_i[IDX_VS_END-VB] < v_i[IDX_V_END-VB]) &&
                  (v_i[IDX_VACT_START-VB] < v_i[IDX_VACT_END-VB]) && (v_i[IDX_VACT_END-VB] <= v_i[IDX_V_END-VB]);
    assign valid_o = h_ok && v_ok;
endmodule

// File: rtl/tpg_timing_ctrl.sv
// tpg_timing_ctrl: stages host timing writes and commits them to the TPG at a frame boundary under reset.
// Ports: clk/rst          - clock, synchronous active-high reset
//        tpg_en           - TPG enable
//        cfg_we/addr/wdata - staging write (ignored while busy, addr 10-15 ignored)
//        commit_req       - level request; answered by a one-cycle commit_ack or commit_err
//        busy             - commit in progress (PEND/APPLY/HOLD)
//        vs_q             - TPG vsync, rising edge marks a frame boundary
//        tpg_rst_n        - TPG reset, low while a new set is applied
//        tHS_START..tV_END - active timing set
//        frame_cnt        - vsync rising edges since the last commit
module tpg_timing_ctrl
    import tpg_pkg::*;
#(
    parameter int H_BITS       = 12,
    parameter int V_BITS       = 12,
    parameter int RST_CYC      = 4,
    parameter int PEND_TIMEOUT = 4194304,
    parameter int FC_BITS      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tpg_en,
    input  logic               cfg_we,
    input  logic [3:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    input  logic               commit_req,
    output logic               commit_ack,
    output logic               commit_err,
    output logic               busy,
    input  logic               vs_q,
    output logic               tpg_rst_n,
    output logic [H_BITS-1:0]  tHS_START,
    output logic [H_BITS-1:0]  tHS_END,
    output logic [H_BITS-1:0]  tHACT_START,
    output logic [H_BITS-1:0]  tHACT_END,
    output logic [H_BITS-1:0]  tH_END,
    output logic [V_BITS-1:0]  tVS_START,
    output logic [V_BITS-1:0]  tVS_END,
    output logic [V_BITS-1:0]  tVACT_START,
    output logic [V_BITS-1:0]  tVACT_END,
    output logic [V_BITS-1:0]  tV_END,
    output logic [FC_BITS-1:0] frame_cnt
);
    localparam int TO_W = $clog2(PEND_TIMEOUT + 1);
    localparam int HC_W = $clog2(RST_CYC + 1);
    state_e                        state_q, state_d;
    logic [NUM_H-1:0][H_BITS-1:0]  h_stg_q, h_stg_d, h_act_q, h_act_d;
    logic [NUM_H-1:0][V_BITS-1:0]  v_stg_q, v_stg_d, v_act_q, v_act_d;
    logic [TO_W-1:0]               to_q, to_d;
    logic [HC_W-1:0]               hc_q, hc_d;
    logic [FC_BITS-1:0]            fc_q, fc_d;
    logic                          ack_q, ack_d, err_q, err_d, run_q, run_d, rstn_q, rstn_d, vs_prev_q;
    logic                          valid, vs_edge, unused_wdata;
    logic [2:0]                    v_idx;
    tpg_timing_check #(.H_BITS(H_BITS), .V_BITS(V_BITS)) u_check (
        .h_i     (h_stg_q),
        .v_i     (v_stg_q),
        .valid_o (valid)
    );
    assign vs_edge      = vs_q & ~vs_prev_q;
    // addresses 5..9 map to vertical slots 0..4 modulo 8
    assign v_idx        = cfg_addr[2:0] - 3'd5;
    assign unused_wdata = ^cfg_wdata;
    always_comb begin
        state_d = state_q;
        h_stg_d = h_stg_q;
        v_stg_d = v_stg_q;
        h_act_d = h_act_q;
        v_act_d = v_act_q;
        to_d    = to_q;
        hc_d    = hc_q;
        fc_d    = fc_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        run_d   = run_q;
        rstn_d  = run_q & tpg_en;
        if (cfg_we && state_q == IDLE) begin
            if (cfg_addr < 4'd5) h_stg_d[cfg_addr[2:0]] = cfg_wdata[H_BITS-1:0];
            else if (cfg_addr < 4'd10) v_stg_d[v_idx] = cfg_wdata[V_BITS-1:0];
        end
        case (state_q)
            IDLE: begin
                if (vs_edge) fc_d = fc_q + 1'b1;
                // a request still high during the ack/err pulse belongs to the finished commit
                if (commit_req && !ack_q && !err_q) begin
                    if (!valid) err_d = 1'b1;
                    else if (run_q && tpg_en) begin
                        state_d = PEND;
                        to_d    = '0;
                    end else state_d = APPLY;
                end
            end
            PEND: begin
                to_d = to_q + 1'b1;
                if (vs_edge || !tpg_en || to_q == TO_W'(PEND_TIMEOUT - 1)) state_d = APPLY;
            end
            APPLY: begin
                h_act_d = h_stg_q;
                v_act_d = v_stg_q;
                rstn_d  = 1'b0;
                hc_d    = HC_W'(RST_CYC - 1);
                fc_d    = '0;
                state_d = HOLD;
            end
            HOLD: begin
                rstn_d = 1'b0;
                hc_d   = hc_q - 1'b1;
                if (hc_q == '0) begin
                    state_d = IDLE;
                    ack_d   = 1'b1;
                    run_d   = 1'b1;
                    rstn_d  = tpg_en;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            h_stg_q   <= '0;
            v_stg_q   <= '0;
            h_act_q   <= '0;
            v_act_q   <= '0;
            to_q      <= '0;
            hc_q      <= '0;
            fc_q      <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
            rstn_q    <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_stg_q   <= h_stg_d;
            v_stg_q   <= v_stg_d;
            h_act_q   <= h_act_d;
            v_act_q   <= v_act_d;
            to_q      <= to_d;
            hc_q      <= hc_d;
            fc_q      <= fc_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            run_q     <= run_d;
            rstn_q    <= rstn_d;
            vs_prev_q <= vs_q;
        end
    end
    assign busy        = state_q != IDLE;
    assign commit_ack  = ack_q;
    assign commit_err  = err_q;
    assign tpg_rst_n   = rstn_q;
    assign frame_cnt   = fc_q;
    assign tHS_START   = h_act_q[IDX_HS_START];
    assign tHS_END     = h_act_q[IDX_HS_END];
    assign tHACT_START = h_act_q[IDX_HACT_START];
    assign tHACT_END   = h_act_q[IDX_HACT_END];
    assign tH_END      = h_act_q[IDX_H_END];
    assign tVS_START   = v_act_q[IDX_VS_START-NUM_H];
    assign tVS_END     = v_act_q[IDX_VS_END-NUM_H];
    assign tVACT_START = v_act_q[IDX_VACT_START-NUM_H];
    assign tVACT_END   = v_act_q[IDX_VACT_END-NUM_H];
    assign tV_END      = v_act_q[IDX_V_END-NUM_H];
endmodule
